mdu_seq: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO result registers.
- Successor to the single-cycle combinational ALU; sits beside it in the execute stage of the pipelined CPU.
- Accepts one operation per start pulse and reports busy so hazard logic can stall mfhi/mflo/mult/div.
- mthi/mtlo write HI/LO directly.

---
 rtl/mdu_if.sv | 16 +
 rtl/mdu_seq.sv | 134 +++++++++++++
 tb/tb_mdu_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Handshake/result bundle between the execute stage and the multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, src_a, src_b, input busy, done, hi, lo);
  modport slave  (input start, op, src_a, src_b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers, busy/done handshake.
// Optional: define MDU_MADD_EN to accept madd/maddu ({hi,lo} += product).
module mdu_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic                 sgn;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod, result;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  // Result datapath works only on the operands latched at acceptance.
  always_comb begin
    sgn    = ~op_q[0];
    ext_a  = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    ext_b  = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    prod   = ext_a * ext_b;

    a_neg  = sgn & a_q[WIDTH-1];
    b_neg  = sgn & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    // Keep the divider defined on x/0; the result is discarded in that case.
    b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;

    case (op_q)
      3'b000, 3'b001: result = prod;
      3'b010, 3'b011: result = (b_q == '0) ? {hi_q, lo_q} : {rem, quo};
`ifdef MDU_MADD_EN
      3'b110, 3'b111: result = {hi_q, lo_q} + prod;
`endif
      default:        result = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
`ifdef MDU_MADD_EN
            3'b000, 3'b001, 3'b110, 3'b111: begin
`else
            3'b000, 3'b001: begin
`endif
              a_d     = bus.src_a;
              b_d     = bus.src_b;
              op_d    = bus.op;
              cnt_d   = CW'(MUL_CYCLES);
              state_d = RUN;
            end
            3'b010, 3'b011: begin
              a_d     = bus.src_a;
              b_d     = bus.src_b;
              op_d    = bus.op;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            3'b100:  hi_d = bus.src_a;
            3'b101:  lo_d = bus.src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Starts are ignored here; the last count writes HI/LO and returns.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = result;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Randomised + directed bench for mdu_seq; results are predicted by a
// plain-arithmetic model and checked by a monitor on each done pulse.
module tb_mdu_seq;
  localparam int W    = 32;
  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_hl = '0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  // Reference semantics: 64-bit integer arithmetic on the architectural values.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          q, r;
    longint unsigned uq, ur;
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return hl;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return hl;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return {a, hl[31:0]};
      3'd5: return {hl[63:32], a};
      3'd6: return MADD ? hl + 64'(sa * sb) : hl;
      default: return MADD ? hl + 64'(ua * ub) : hl;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op <= 3'd1) return MULC;
    if (op <= 3'd3) return DIVC;
    if (op >= 3'd6 && MADD) return MULC;
    return 0;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 hi=%h lo=%h expected no done", bus.hi, bus.lo);
      end else begin
        check("result_hilo", {bus.hi, bus.lo}, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    int cnt;
    logic [63:0] e;
    n = latency(op);
    e = model(op, a, b, model_hl);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    if (n > 0) exp_q.push_back(e);
    model_hl = e;
    @(negedge clk);
    bus.start = 1'b0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    if (n > 0) begin
      cnt = 0;
      while (bus.busy && cnt < 200) begin
        cnt++;
        @(negedge clk);
      end
      check($sformatf("busy_len op%0d", op), 64'(cnt), 64'(n));
      check("done_after_busy", 64'(bus.done), 64'd1);
    end else begin
      check($sformatf("no_busy op%0d", op), 64'(bus.busy), 64'd0);
      check($sformatf("direct_hilo op%0d", op), {bus.hi, bus.lo}, model_hl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          cnt;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    #1 reset = 1'b0;
    #2;
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd4, 32'h11, 32'd0);
    run_op(3'd5, 32'h22, 32'd0);
    run_op(3'd3, 32'd5, 32'd0);
    run_op(3'd6, 32'd3, 32'd7);
    run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op(3'd4, 32'd0, 32'd0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0);
    run_op(3'd7, 32'd1, 32'd1);
`endif

    // Starts during busy are dropped; a start in the first idle cycle is taken.
    run_op(3'd4, 32'd0, 32'd0);
    run_op(3'd5, 32'd0, 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.src_a = 32'd3;
    bus.src_b = 32'd4;
    model_hl  = model(3'd1, 32'd3, 32'd4, model_hl);
    exp_q.push_back(model_hl);
    @(negedge clk);
    bus.op    = 3'd5;
    bus.src_a = 32'hAA;
    @(negedge clk);
    bus.op    = 3'd2;
    bus.src_a = 32'd9;
    bus.src_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_ignore_hilo", {bus.hi, bus.lo}, 64'd12);
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.src_a = 32'hAA;
    model_hl  = {model_hl[63:32], 32'hAA};
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_after_busy", {bus.hi, bus.lo}, model_hl);

    // Asynchronous reset in the third busy cycle of a mult aborts it.
    run_op(3'd4, 32'h1234, 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.src_a = 32'd5;
    bus.src_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check("abort_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    model_hl = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("no_result_after_abort", {bus.hi, bus.lo}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op(op, a, b);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
